// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end: the layout of a
// buffered fetch entry and the architectural boot/exception vectors.
package inst_fetch_unit_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  // Bit offsets of each field inside a flattened 66-bit fetch entry
  localparam int BUSERR_OFS = 0;
  localparam int ADEL_OFS   = 1;
  localparam int INSTR_OFS  = 2;
  localparam int PC_OFS     = INSTR_OFS + INSTR_W;
  localparam int ENTRY_W    = PC_OFS + PC_W;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VECTOR   = 32'hBFC0_0380;

  // Field order matches the offsets above (pc in the MSBs, buserr in bit 0)
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               adel;
    logic               buserr;
  } fetchEntry_t;

  // Builds an entry; the instruction word is forced to zero whenever an
  // exception flag is set so decode never sees stale bus data.
  function automatic fetchEntry_t makeEntry(input logic [PC_W-1:0]    pc,
                                            input logic [INSTR_W-1:0] instr,
                                            input logic               adel,
                                            input logic               buserr);
    fetchEntry_t e;
    e.pc     = pc;
    e.instr  = (adel || buserr) ? '0 : instr;
    e.adel   = adel;
    e.buserr = buserr;
    return e;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_sync.sv
// Small synchronous FIFO with a registered head. Push and pop in the same
// cycle are legal at any fill level, including full. Depth need not be a
// power of two (the pending-PC queue uses the outstanding limit as depth).
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         push,
  input  logic [WIDTH-1:0]             pushData,
  input  logic                         pop,
  output logic [WIDTH-1:0]             headData,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  function automatic logic [AW-1:0] nextPtr(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + AW'(1);
  endfunction

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign doPop    = pop && !empty;
  assign doPush   = push && (!full || doPop);
  assign headData = mem[rdPtr];

  // Storage array; no reset needed since count gates every read
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= pushData;
    end
  end

  // Pointer and occupancy bookkeeping; clear empties the queue in one edge
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= nextPtr(wrPtr);
      end
      if (doPop) begin
        rdPtr <= nextPtr(rdPtr);
      end
      if (doPush && !doPop) begin
        count <= count + CW'(1);
      end else if (!doPush && doPop) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch front end: turns PCs into instruction-bus reads, tracks reads in
// flight, buffers returned words (with their PC and exception flags) in an
// in-order FIFO for decode, and throws away reads orphaned by a redirect.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_OUT    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        flush_i,
  output logic        pc_advance_o,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  input  logic        ibus_err_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_pc_o,
  output logic [31:0] out_instr_o,
  output logic        out_adel_o,
  output logic        out_buserr_o
);

  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int OCW = $clog2(MAX_OUT + 1);
  localparam logic [31:0] DEPTH_L  = 32'(FIFO_DEPTH);
  localparam logic [31:0] MAXOUT_L = 32'(MAX_OUT);

  logic [OCW-1:0]     outstanding;
  logic [OCW-1:0]     outstandingNext;
  logic [OCW-1:0]     discard;
  logic [OCW-1:0]     discardNext;
  logic               halted;
  logic               haltedNext;

  logic [FCW-1:0]     fifoCount;
  logic               fifoFull;
  logic               fifoEmpty;
  logic [ENTRY_W-1:0] headBits;
  fetchEntry_t        headEntry;
  fetchEntry_t        pushEntry;

  logic [OCW-1:0]     pendCount;
  logic [31:0]        pendHead;
  logic               pendFull;
  logic               pendEmpty;

  logic [31:0]        occupancy;
  logic               credit;
  logic               aligned;
  logic               grant;
  logic               respValid;
  logic               respAccept;
  logic               respDrop;
  logic               adelPush;
  logic               fifoPush;
  logic               fifoPop;

  // Decode this cycle's bus request, responses, misaligned-PC entry and pops.
  // Credit counts every read in flight (even ones to be discarded) against
  // the FIFO so that every possible response always has a slot waiting.
  // A misaligned PC is only reported once the bus is idle, so the exception
  // entry lands behind all older instructions and never collides with a
  // response push in the same cycle.
  always_comb begin
    occupancy  = 32'(outstanding) + 32'(fifoCount);
    credit     = (occupancy < DEPTH_L) && (32'(outstanding) < MAXOUT_L);
    aligned    = (pc_i[1:0] == 2'b00);
    ibus_req_o = !rst && !flush_i && !halted && credit && aligned;
    grant      = ibus_req_o && ibus_gnt_i;
    respValid  = ibus_rvalid_i && (outstanding != '0);
    respAccept = respValid && !flush_i && (discard == '0);
    respDrop   = respValid && !respAccept;
    adelPush   = !rst && !flush_i && !halted && !aligned &&
                 (outstanding == '0) && !fifoFull;
    fifoPush   = adelPush || respAccept;
    fifoPop    = !fifoEmpty && out_ready_i && !flush_i;
  end

  assign pc_advance_o = grant;
  assign ibus_addr_o  = pc_i;

  // Select what goes into the fetch FIFO: an address-error marker or a bus response
  always_comb begin
    pushEntry = '0;
    if (adelPush) begin
      pushEntry = makeEntry(pc_i, 32'h0, 1'b1, 1'b0);
    end else begin
      pushEntry = makeEntry(pendHead, ibus_rdata_i, 1'b0, ibus_err_i);
    end
  end

  // Next values of the in-flight, discard and halt bookkeeping.
  // On a redirect every read still in flight becomes garbage; reads already
  // marked for discard are part of the outstanding count, so the new discard
  // total is simply what remains outstanding after this cycle's response.
  always_comb begin
    outstandingNext = outstanding;
    discardNext     = discard;
    haltedNext      = halted;
    if (grant && !respValid) begin
      outstandingNext = outstanding + OCW'(1);
    end else if (!grant && respValid) begin
      outstandingNext = outstanding - OCW'(1);
    end
    if (flush_i) begin
      discardNext = respValid ? (outstanding - OCW'(1)) : outstanding;
      haltedNext  = 1'b0;
    end else begin
      if (respDrop) begin
        discardNext = discard - OCW'(1);
      end
      if (adelPush || (respAccept && ibus_err_i)) begin
        haltedNext = 1'b1;
      end
    end
  end

  // State register for the bookkeeping counters and the halt flag
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      discard     <= '0;
      halted      <= 1'b0;
    end else begin
      outstanding <= outstandingNext;
      discard     <= discardNext;
      halted      <= haltedNext;
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) fetchFifo (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush_i),
    .push     (fifoPush),
    .pushData (pushEntry),
    .pop      (fifoPop),
    .headData (headBits),
    .count    (fifoCount),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (MAX_OUT)
  ) pendingQueue (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush_i),
    .push     (grant),
    .pushData (pc_i),
    .pop      (respAccept),
    .headData (pendHead),
    .count    (pendCount),
    .full     (pendFull),
    .empty    (pendEmpty)
  );

  assign headEntry    = fetchEntry_t'(headBits);
  assign out_valid_o  = !fifoEmpty;
  assign out_pc_o     = out_valid_o ? headEntry.pc     : 32'h0;
  assign out_instr_o  = out_valid_o ? headEntry.instr  : 32'h0;
  assign out_adel_o   = out_valid_o && headEntry.adel;
  assign out_buserr_o = out_valid_o && headEntry.buserr;

  // A response with nothing in flight breaks the bus protocol; it is ignored
  rvalidNeedsRead: assert property (@(posedge clk) disable iff (rst)
    !(ibus_rvalid_i && (outstanding == '0)));

  // Live reads in flight are exactly those whose PCs sit in the pending queue
  pendingMatchesLive: assert property (@(posedge clk) disable iff (rst)
    (32'(pendCount) + 32'(discard)) == 32'(outstanding));

  // Credit must guarantee a slot for every push
  fetchFifoNoOverflow: assert property (@(posedge clk) disable iff (rst)
    !(fifoPush && fifoFull && !fifoPop));

  pendingNoOverflow: assert property (@(posedge clk) disable iff (rst)
    !(grant && pendFull));

  pendingNoUnderflow: assert property (@(posedge clk) disable iff (rst)
    !(respAccept && pendEmpty));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios followed by a
// randomized run, all checked against a transaction-level model built from
// a list of bus reads in flight and a list of entries decode should see.
module tb_inst_fetch_unit;

  localparam int FIFO_DEPTH = 4;
  localparam int MAX_OUT    = 2;
  localparam logic [31:0] RESET_VEC = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VEC   = 32'hBFC0_0380;

  logic        clk;
  logic        rst;
  logic [31:0] pc_i;
  logic        flush_i;
  logic        pc_advance_o;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i;
  logic        ibus_rvalid_i;
  logic [31:0] ibus_rdata_i;
  logic        ibus_err_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_pc_o;
  logic [31:0] out_instr_o;
  logic        out_adel_o;
  logic        out_buserr_o;

  inst_fetch_unit #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .MAX_OUT    (MAX_OUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_i          (pc_i),
    .flush_i       (flush_i),
    .pc_advance_o  (pc_advance_o),
    .ibus_req_o    (ibus_req_o),
    .ibus_addr_o   (ibus_addr_o),
    .ibus_gnt_i    (ibus_gnt_i),
    .ibus_rvalid_i (ibus_rvalid_i),
    .ibus_rdata_i  (ibus_rdata_i),
    .ibus_err_i    (ibus_err_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_pc_o      (out_pc_o),
    .out_instr_o   (out_instr_o),
    .out_adel_o    (out_adel_o),
    .out_buserr_o  (out_buserr_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { logic [31:0] pc; bit live; } read_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; logic adel; logic buserr; } entry_t;

  read_t  inflight[$];
  entry_t expQ[$];
  bit     mHalted;
  logic [31:0] tbPc;

  int testsRun;
  int testsFailed;
  int cycleNo;

  logic        expReq, expAdv, obsReq, obsAdv;
  logic [31:0] obsAddr, drivenPc;

  task automatic doReset();
    rst = 1'b1; flush_i = 1'b0; ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0;
    ibus_err_i = 1'b0; out_ready_i = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    inflight.delete(); expQ.delete(); mHalted = 0; tbPc = RESET_VEC;
  endtask

  // One clock of stimulus; the model advances alongside. Starts and ends at a negedge.
  task automatic driveCycle(input logic fl, input logic [31:0] target, input logic gnt,
                            input logic rv, input logic [31:0] rd, input logic err,
                            input logic rdy);
    read_t  r;
    entry_t e;
    bit     respLive, aligned, credit, doAdel, doPop;
    drivenPc = tbPc;
    pc_i = tbPc; flush_i = fl; ibus_gnt_i = gnt; out_ready_i = rdy;
    ibus_rvalid_i = rv && (inflight.size() > 0);
    ibus_rdata_i = rd; ibus_err_i = err;
    #1;
    aligned = (tbPc[1:0] == 2'b00);
    credit  = (inflight.size() + expQ.size() < FIFO_DEPTH) && (inflight.size() < MAX_OUT);
    expReq  = !fl && !mHalted && credit && aligned;
    expAdv  = expReq && gnt;
    obsReq = ibus_req_o; obsAdv = pc_advance_o; obsAddr = ibus_addr_o;
    doAdel = !fl && !mHalted && !aligned && (inflight.size() == 0) && (expQ.size() < FIFO_DEPTH);
    doPop  = !fl && rdy && (expQ.size() > 0);
    respLive = 0;
    r.pc = '0; r.live = 0;
    if (ibus_rvalid_i) begin
      r = inflight.pop_front();
      respLive = r.live && !fl;
    end
    if (doPop) e = expQ.pop_front();
    if (fl) begin
      expQ.delete();
      for (int i = 0; i < inflight.size(); i++) inflight[i].live = 0;
      mHalted = 0;
    end else if (respLive) begin
      e.pc = r.pc; e.instr = err ? 32'h0 : rd; e.adel = 1'b0; e.buserr = err;
      expQ.push_back(e);
      if (err) mHalted = 1;
    end else if (doAdel) begin
      e.pc = tbPc; e.instr = 32'h0; e.adel = 1'b1; e.buserr = 1'b0;
      expQ.push_back(e);
      mHalted = 1;
    end
    if (expAdv) begin
      r.pc = tbPc; r.live = 1;
      inflight.push_back(r);
    end
    if (fl) tbPc = target;
    else if (expAdv) tbPc = tbPc + 32'd4;
    cycleNo++;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; pc_i = RESET_VEC; flush_i = 1'b0; ibus_gnt_i = 1'b1; ibus_rvalid_i = 1'b0;
    ibus_rdata_i = '0; ibus_err_i = 1'b0; out_ready_i = 1'b0;
    #1;
    testsRun++;
    if (ibus_req_o !== 1'b0 || pc_advance_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_req: got req=%b adv=%b, want 0 0", ibus_req_o, pc_advance_o);
    end
    @(posedge clk); @(posedge clk); @(negedge clk);
    testsRun++;
    if ({out_valid_o, out_adel_o, out_buserr_o} !== 3'b000) begin
      testsFailed++;
      $display("[TB] FAIL reset_flags: got valid/adel/buserr=%b, want 000",
               {out_valid_o, out_adel_o, out_buserr_o});
    end
    testsRun++;
    if (out_pc_o !== 32'h0 || out_instr_o !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_data: got pc=%h instr=%h, want 0 0", out_pc_o, out_instr_o);
    end
    ibus_gnt_i = 1'b0; rst = 1'b0;
    inflight.delete(); expQ.delete(); mHalted = 0; tbPc = RESET_VEC;
    #1;
    testsRun++;
    if (ibus_req_o !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL req_after_reset: got %b, want 1", ibus_req_o);
    end
    @(negedge clk);
  endtask

  task automatic test_first_fetch();
    doReset();
    driveCycle(0, '0, 1, 0, '0, 0, 0);
    testsRun++;
    if (obsAdv !== 1'b1 || obsAddr !== RESET_VEC) begin
      testsFailed++;
      $display("[TB] FAIL first_grant: got adv=%b addr=%h, want 1 %h", obsAdv, obsAddr, RESET_VEC);
    end
    testsRun++;
    if (out_valid_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL first_not_early: got valid=%b, want 0", out_valid_o);
    end
    driveCycle(0, '0, 0, 1, 32'h3C08BFC0, 0, 0);
    testsRun++;
    if ({out_valid_o, out_pc_o, out_instr_o, out_adel_o, out_buserr_o} !==
        {1'b1, RESET_VEC, 32'h3C08BFC0, 2'b00}) begin
      testsFailed++;
      $display("[TB] FAIL first_entry: got v=%b pc=%h instr=%h flags=%b%b, want 1 %h 3c08bfc0 00",
               out_valid_o, out_pc_o, out_instr_o, out_adel_o, out_buserr_o, RESET_VEC);
    end
  endtask

  task automatic test_fifo_full();
    int grants;
    doReset();
    grants = 0;
    for (int i = 0; i < 6; i++) begin
      driveCycle(0, '0, 1, 1, 32'h1000_0000 + 32'(i), 0, 0);
      if (obsAdv === 1'b1) grants++;
    end
    testsRun++;
    if (grants != 4) begin
      testsFailed++;
      $display("[TB] FAIL full_grants: got %0d grants, want 4", grants);
    end
    testsRun++;
    if (obsReq !== 1'b0 || obsAdv !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL full_stall: got req=%b adv=%b, want 0 0", obsReq, obsAdv);
    end
    for (int i = 0; i < 4; i++) begin
      testsRun++;
      if (out_valid_o !== 1'b1 || out_pc_o !== RESET_VEC + 32'(4 * i)) begin
        testsFailed++;
        $display("[TB] FAIL drain_order[%0d]: got v=%b pc=%h, want 1 %h",
                 i, out_valid_o, out_pc_o, RESET_VEC + 32'(4 * i));
      end
      driveCycle(0, '0, 0, 0, '0, 0, 1);
      if (i == 1) begin
        testsRun++;
        if (obsReq !== 1'b1 || obsAddr !== RESET_VEC + 32'h10) begin
          testsFailed++;
          $display("[TB] FAIL resume_req: got req=%b addr=%h, want 1 %h",
                   obsReq, obsAddr, RESET_VEC + 32'h10);
        end
      end
    end
    testsRun++;
    if (out_valid_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL drain_empty: got valid=%b, want 0", out_valid_o);
    end
  endtask

  task automatic test_flush();
    doReset();
    driveCycle(0, '0, 1, 0, '0, 0, 0);
    driveCycle(0, '0, 1, 0, '0, 0, 0);
    driveCycle(1, EXC_VEC, 1, 0, '0, 0, 0);
    testsRun++;
    if (obsReq !== 1'b0 || obsAdv !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL flush_no_req: got req=%b adv=%b, want 0 0", obsReq, obsAdv);
    end
    driveCycle(0, '0, 0, 1, 32'hAAAA_0001, 0, 0);
    driveCycle(0, '0, 0, 1, 32'hAAAA_0002, 0, 0);
    testsRun++;
    if (out_valid_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL flush_dropped: got valid=%b, want 0", out_valid_o);
    end
    driveCycle(0, '0, 1, 0, '0, 0, 0);
    driveCycle(0, '0, 0, 1, 32'h2408_0001, 0, 0);
    testsRun++;
    if (out_valid_o !== 1'b1 || out_pc_o !== EXC_VEC || out_instr_o !== 32'h2408_0001) begin
      testsFailed++;
      $display("[TB] FAIL flush_target: got v=%b pc=%h instr=%h, want 1 %h 24080001",
               out_valid_o, out_pc_o, out_instr_o, EXC_VEC);
    end
  endtask

  task automatic test_flush_with_response();
    doReset();
    driveCycle(0, '0, 1, 0, '0, 0, 0);
    driveCycle(0, '0, 1, 0, '0, 0, 0);
    driveCycle(1, EXC_VEC, 0, 1, 32'hBBBB_0001, 0, 0);
    driveCycle(0, '0, 1, 1, 32'hBBBB_0002, 0, 0);
    testsRun++;
    if (out_valid_o !== 1'b0 || obsAdv !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL flushresp_drop: got valid=%b adv=%b, want 0 1", out_valid_o, obsAdv);
    end
    driveCycle(0, '0, 0, 1, 32'h3C1D_8000, 0, 0);
    testsRun++;
    if (out_valid_o !== 1'b1 || out_pc_o !== EXC_VEC || out_instr_o !== 32'h3C1D_8000) begin
      testsFailed++;
      $display("[TB] FAIL flushresp_keep: got v=%b pc=%h instr=%h, want 1 %h 3c1d8000",
               out_valid_o, out_pc_o, out_instr_o, EXC_VEC);
    end
  endtask

  task automatic test_adel();
    doReset();
    tbPc = 32'hBFC0_0002;
    driveCycle(0, '0, 1, 0, '0, 0, 0);
    testsRun++;
    if (obsReq !== 1'b0 || obsAdv !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL adel_no_req: got req=%b adv=%b, want 0 0", obsReq, obsAdv);
    end
    testsRun++;
    if ({out_valid_o, out_pc_o, out_instr_o, out_adel_o, out_buserr_o} !==
        {1'b1, 32'hBFC0_0002, 32'h0, 2'b10}) begin
      testsFailed++;
      $display("[TB] FAIL adel_entry: got v=%b pc=%h instr=%h adel=%b buserr=%b, want 1 bfc00002 0 1 0",
               out_valid_o, out_pc_o, out_instr_o, out_adel_o, out_buserr_o);
    end
    tbPc = 32'hBFC0_0004;
    for (int i = 0; i < 3; i++) begin
      driveCycle(0, '0, 1, 0, '0, 0, 1);
      testsRun++;
      if (obsReq !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL adel_halted[%0d]: got req=%b, want 0", i, obsReq);
      end
    end
    driveCycle(1, EXC_VEC, 1, 0, '0, 0, 0);
    driveCycle(0, '0, 1, 0, '0, 0, 0);
    testsRun++;
    if (obsReq !== 1'b1 || obsAddr !== EXC_VEC) begin
      testsFailed++;
      $display("[TB] FAIL adel_restart: got req=%b addr=%h, want 1 %h", obsReq, obsAddr, EXC_VEC);
    end
  endtask

  task automatic test_buserr();
    doReset();
    tbPc = 32'hBFC0_0010;
    driveCycle(0, '0, 1, 0, '0, 0, 0);
    driveCycle(0, '0, 0, 1, 32'hDEAD_BEEF, 1, 0);
    testsRun++;
    if ({out_valid_o, out_pc_o, out_instr_o, out_adel_o, out_buserr_o} !==
        {1'b1, 32'hBFC0_0010, 32'h0, 2'b01}) begin
      testsFailed++;
      $display("[TB] FAIL buserr_entry: got v=%b pc=%h instr=%h adel=%b buserr=%b, want 1 bfc00010 0 0 1",
               out_valid_o, out_pc_o, out_instr_o, out_adel_o, out_buserr_o);
    end
    for (int i = 0; i < 2; i++) begin
      driveCycle(0, '0, 1, 0, '0, 0, 0);
      testsRun++;
      if (obsReq !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL buserr_halted[%0d]: got req=%b, want 0", i, obsReq);
      end
    end
    driveCycle(1, EXC_VEC, 1, 0, '0, 0, 0);
    driveCycle(0, '0, 1, 0, '0, 0, 0);
    testsRun++;
    if (obsAdv !== 1'b1 || obsAddr !== EXC_VEC) begin
      testsFailed++;
      $display("[TB] FAIL buserr_restart: got adv=%b addr=%h, want 1 %h", obsAdv, obsAddr, EXC_VEC);
    end
    driveCycle(0, '0, 0, 1, 32'h0000_000C, 0, 0);
  endtask

  task automatic test_reset_midop();
    doReset();
    driveCycle(0, '0, 1, 0, '0, 0, 0);
    driveCycle(0, '0, 1, 1, 32'h1111_1111, 0, 0);
    doReset();
    pc_i = RESET_VEC;
    #1;
    testsRun++;
    if (out_valid_o !== 1'b0 || ibus_req_o !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL midop_reset: got valid=%b req=%b, want 0 1", out_valid_o, ibus_req_o);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic        fl, gnt, rv, err, rdy;
    logic [31:0] target;
    logic [65:0] expHead;
    doReset();
    for (int n = 0; n < 3000; n++) begin
      fl     = ($urandom_range(0, 11) == 0);
      target = $urandom();
      target[1:0] = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
      gnt    = ($urandom_range(0, 9) < 7);
      rv     = ($urandom_range(0, 1) == 0);
      err    = ($urandom_range(0, 31) == 0);
      rdy    = ($urandom_range(0, 9) < 6);
      driveCycle(fl, target, gnt, rv, $urandom(), err, rdy);
      testsRun++;
      if (obsReq !== expReq || obsAdv !== expAdv) begin
        testsFailed++;
        $display("[TB] FAIL rand_req cycle %0d: got req=%b adv=%b, want %b %b",
                 cycleNo, obsReq, obsAdv, expReq, expAdv);
      end
      testsRun++;
      if (obsAddr !== drivenPc) begin
        testsFailed++;
        $display("[TB] FAIL rand_addr cycle %0d: got %h, want %h", cycleNo, obsAddr, drivenPc);
      end
      testsRun++;
      if (out_valid_o !== (expQ.size() > 0)) begin
        testsFailed++;
        $display("[TB] FAIL rand_valid cycle %0d: got %b, want %b", cycleNo, out_valid_o, expQ.size() > 0);
      end
      if (expQ.size() > 0) expHead = {expQ[0].pc, expQ[0].instr, expQ[0].adel, expQ[0].buserr};
      else expHead = '0;
      testsRun++;
      if ({out_pc_o, out_instr_o, out_adel_o, out_buserr_o} !== expHead) begin
        testsFailed++;
        $display("[TB] FAIL rand_head cycle %0d: got %h, want %h", cycleNo,
                 {out_pc_o, out_instr_o, out_adel_o, out_buserr_o}, expHead);
      end
    end
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    cycleNo = 0;
    test_reset();
    test_first_fetch();
    test_fifo_full();
    test_flush();
    test_flush_with_response();
    test_adel();
    test_buserr();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
